// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge and exception flush sequencer.
// Optional stall watchdog enabled by defining STALL_WDT_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_BASE      = 32'h00000020,
  parameter int unsigned DRAIN_CYCLES  = 2,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    DRAIN
  } state_t;

  localparam logic [31:0] ERET = 32'h0000000e;
  localparam logic [3:0] DRAIN_LD =
    (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

  state_t     state;
  logic [3:0] cnt;
  logic       exc;

  assign exc = |excepttype_i;

  // Stall vector: freeze all on exception, idle in flush, else priority merge
  always_comb begin
    stall = 6'b000000;
    if (!rst) begin
      stall = 6'b000000;
    end else if (state == IDLE && exc) begin
      stall = 6'b111111;
    end else if (state != FLUSH) begin
      if (stallreq_from_mem)     stall = 6'b011111;
      else if (stallreq_from_ex) stall = 6'b001111;
      else if (stallreq_from_id) stall = 6'b000111;
      else if (stallreq_from_if) stall = 6'b000011;
      else                       stall = 6'b000000;
    end
  end

  // Exception sequencer: detect, one-cycle flush, drain window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      flush  <= 1'b0;
      new_pc <= 32'h0;
      cnt    <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (exc) begin
            state  <= FLUSH;
            flush  <= 1'b1;
            new_pc <= (excepttype_i == ERET) ? cp0_epc_i : EXC_BASE;
          end
        end
        FLUSH: begin
          flush <= 1'b0;
          if (DRAIN_CYCLES > 0) begin
            state <= DRAIN;
            cnt   <= DRAIN_LD;
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (cnt == 4'd0) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_WDT_EN
  localparam int WW =
    ($clog2(STALL_TIMEOUT + 1) < 8) ? 8 : $clog2(STALL_TIMEOUT + 1);
  localparam logic [WW-1:0] TO = WW'(STALL_TIMEOUT);

  logic [WW-1:0] wcnt;
  logic          wflag;

  // Watchdog: count consecutive stalled cycles, sticky flag at timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt  <= '0;
      wflag <= 1'b0;
    end else if (state == FLUSH || stall == 6'b000000) begin
      wcnt <= '0;
    end else begin
      if (wcnt != TO) wcnt <= wcnt + WW'(1);
      if (wcnt >= TO - WW'(1)) wflag <= 1'b1;
    end
  end

  assign stall_timeout_o = wflag;
`else
  assign stall_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl
// against a window-counting reference model.
module tb_pipe_ctrl;

  localparam int D  = 2;
  localparam int TO = 255;
  localparam logic [31:0] BASE = 32'h00000020;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rq_if = 1'b0;
  logic        rq_id = 1'b0;
  logic        rq_ex = 1'b0;
  logic        rq_mem = 1'b0;
  logic [31:0] exc = 32'h0;
  logic [31:0] epc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        tmo;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_win;
  logic [31:0] m_pc;
  int          m_wcnt;
  logic        m_wflag;

  pipe_ctrl #(
    .EXC_BASE(BASE),
    .DRAIN_CYCLES(D),
    .STALL_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stallreq_from_if(rq_if),
    .stallreq_from_id(rq_id),
    .stallreq_from_ex(rq_ex),
    .stallreq_from_mem(rq_mem),
    .excepttype_i(exc),
    .cp0_epc_i(epc),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .stall_timeout_o(tmo)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] exp_stall();
    int n;
    if (!rst) return 6'd0;
    if (m_win == 0 && exc != 0) return 6'h3f;
    if (m_win == D + 1) return 6'd0;
    n = rq_mem ? 5 : rq_ex ? 4 : rq_id ? 3 : rq_if ? 2 : 0;
    return (n == 0) ? 6'd0 : 6'((1 << n) - 1);
  endfunction

  task automatic model_reset();
    m_win   = 0;
    m_pc    = 32'h0;
    m_wcnt  = 0;
    m_wflag = 1'b0;
  endtask

  task automatic model_step();
    logic [5:0] s;
    s = exp_stall();
    if (s != 0 && m_win != D + 1) begin
      if (m_wcnt < TO) m_wcnt++;
    end else begin
      m_wcnt = 0;
    end
`ifdef STALL_WDT_EN
    if (m_wcnt >= TO) m_wflag = 1'b1;
`endif
    if (m_win > 0) begin
      m_win--;
    end else if (exc != 0) begin
      m_win = D + 1;
      m_pc  = (exc == 32'h0000000e) ? epc : BASE;
    end
  endtask

  task automatic drive(input logic i, input logic d, input logic e,
                       input logic m, input logic [31:0] x,
                       input logic [31:0] p);
    rq_if  = i;
    rq_id  = d;
    rq_ex  = e;
    rq_mem = m;
    exc    = x;
    epc    = p;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    drive(1, 1, 1, 1, 32'h8, 32'h1234);
    #1;
    n_tests++;
    if (stall !== 6'd0) begin
      n_fail++;
      $display("FAIL rst_stall got %b exp %b", stall, 6'd0);
    end
    n_tests++;
    if (flush !== 1'b0 || new_pc !== 32'h0 || tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_outs got %b %h %b exp 0 0 0", flush, new_pc, tmo);
    end
    do_reset();
    for (int k = 0; k < 10; k++) begin
      #1;
      n_tests++;
      if (stall !== 6'd0 || flush !== 1'b0 || new_pc !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_%0d got %b %b %h exp 0 0 0",
                 k, stall, flush, new_pc);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    logic [5:0] exp [4];
    exp = '{6'b011111, 6'b000111, 6'b000011, 6'b001111};
    for (int k = 0; k < 4; k++) begin
      unique case (k)
        0: drive(0, 1, 0, 1, 0, 0);
        1: drive(0, 1, 0, 0, 0, 0);
        2: drive(1, 0, 0, 0, 0, 0);
        default: drive(1, 1, 1, 0, 0, 0);
      endcase
      #1;
      n_tests++;
      if (stall !== exp[k]) begin
        n_fail++;
        $display("FAIL prio_%0d got %b exp %b", k, stall, exp[k]);
      end
      tick();
    end
  endtask

  task automatic test_exception();
    drive(0, 1, 0, 0, 32'h8, 32'h0);
    #1;
    n_tests++;
    if (stall !== 6'h3f) begin
      n_fail++;
      $display("FAIL exc_freeze got %b exp %b", stall, 6'h3f);
    end
    tick();
    drive(0, 0, 0, 1, 0, 0);
    #1;
    n_tests++;
    if (flush !== 1'b1 || new_pc !== 32'h20 || stall !== 6'd0) begin
      n_fail++;
      $display("FAIL exc_flush got %b %h %b exp 1 00000020 000000",
               flush, new_pc, stall);
    end
    tick();
    for (int k = 0; k < D; k++) begin
      #1;
      n_tests++;
      if (flush !== 1'b0 || stall !== 6'b011111) begin
        n_fail++;
        $display("FAIL exc_drain_%0d got %b %b exp 0 011111",
                 k, flush, stall);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_tests++;
    if (flush !== 1'b0 || new_pc !== 32'h20 || stall !== 6'd0) begin
      n_fail++;
      $display("FAIL exc_after got %b %h %b exp 0 00000020 000000",
               flush, new_pc, stall);
    end
    tick();
  endtask

  task automatic test_eret();
    drive(0, 0, 0, 0, 32'he, 32'h30000040);
    tick();
    drive(0, 0, 0, 0, 0, 32'h0);
    #1;
    n_tests++;
    if (flush !== 1'b1 || new_pc !== 32'h30000040) begin
      n_fail++;
      $display("FAIL eret got %b %h exp 1 30000040", flush, new_pc);
    end
    for (int k = 0; k < D + 1; k++) tick();
  endtask

  task automatic test_drain();
    drive(0, 0, 0, 0, 32'h8, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < D; k++) begin
      drive(0, 0, 0, 0, 32'hc, 0);
      #1;
      n_tests++;
      if (stall !== 6'd0 || flush !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_exc_%0d got %b %b exp 000000 0",
                 k, stall, flush);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (flush !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_noflush_%0d got %b exp 0", k, flush);
      end
      tick();
    end
    drive(0, 0, 0, 0, 32'h1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0, 0);
    #1;
    n_tests++;
    if (stall !== 6'b001111) begin
      n_fail++;
      $display("FAIL drain_req got %b exp %b", stall, 6'b001111);
    end
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (stall !== 6'd0 || flush !== 1'b0 || new_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL drain_rst got %b %b %h exp 0 0 0",
               stall, flush, new_pc);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_watchdog();
    logic exp;
    do_reset();
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= TO + 10; i++) begin
      tick();
      if (i == TO - 1 || i == TO || i == TO + 10) begin
`ifdef STALL_WDT_EN
        exp = (i >= TO);
`else
        exp = 1'b0;
`endif
        n_tests++;
        if (tmo !== exp) begin
          n_fail++;
          $display("FAIL wdt_%0d got %b exp %b", i, tmo, exp);
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
`ifdef STALL_WDT_EN
    exp = 1'b1;
`else
    exp = 1'b0;
`endif
    n_tests++;
    if (tmo !== exp) begin
      n_fail++;
      $display("FAIL wdt_sticky got %b exp %b", tmo, exp);
    end
  endtask

  task automatic test_random();
    logic [31:0] codes [6];
    logic [5:0]  es;
    int          k;
    codes = '{32'h1, 32'h8, 32'h9, 32'ha, 32'hc, 32'he};
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rq_if  = ($urandom_range(0, 9) < 3);
      rq_id  = ($urandom_range(0, 9) < 3);
      rq_ex  = ($urandom_range(0, 9) < 3);
      rq_mem = ($urandom_range(0, 9) < 2);
      epc    = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        k   = $urandom_range(0, 6);
        exc = (k == 6) ? $urandom : codes[k];
      end else begin
        exc = 32'h0;
      end
      #1;
      es = exp_stall();
      n_tests++;
      if (stall !== es || flush !== (m_win == D + 1) ||
          new_pc !== m_pc || tmo !== m_wflag) begin
        n_fail++;
        $display("FAIL rand_%0d got %b %b %h %b exp %b %b %h %b",
                 n, stall, flush, new_pc, tmo,
                 es, (m_win == D + 1), m_pc, m_wflag);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_exception();
    test_eret();
    test_drain();
    test_watchdog();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
